data_mem_responder: RTL and testbench

- Responder end of the core's data-memory port. It accepts MemAddr, MemRead, MemWrite, WriteL, WriteR and WriteData from the processor's M stage.
- Returns MemData one cycle later, in time for the WB stage.
- Holds a synchronous word array with per-byte-lane writes for SWL, SWR and SB.
- Zero-fills the array after reset using an init state machine, and flags bad addresses.

---
 rtl/data_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of the core's data-memory port. Holds a 2^ADDR_W x 32-bit
// word array with big-endian byte lanes (lane k = bits [31-8k:24-8k]) and
// supports full-word, SWL, SWR and byte stores. Read data is registered and
// returned one cycle after the request. After reset the array is zero-filled
// by an init sequence. Requests arriving before Ready is high are ignored.
//
// Optional feature macro: DATA_MEM_STATS_EN adds saturating read/write
// counters (ReadCount_o / WriteCount_o).
//
// Ports:
//   Clock_i       system clock, rising edge
//   Reset_i       synchronous, active-high reset
//   MemAddr_i     byte address from the core
//   MemRead_i     read request
//   MemWrite_i    write request
//   WriteL_i      left-partial store (SWL)
//   WriteR_i      right-partial store (SWR); both set = byte store
//   WriteData_i   lane-aligned store data
//   MemData_o     registered read data
//   Ready_o       high once zero-fill is complete
//   AddrErr_o     one-cycle pulse in the response cycle of a bad request
//   ReadCount_o   (DATA_MEM_STATS_EN) accepted reads, saturating
//   WriteCount_o  (DATA_MEM_STATS_EN) accepted writes, saturating
//
// state | meaning
// INIT  | zero-filling word[init_cnt], requests ignored
// IDLE  | servicing requests, Ready high
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic [15:0] MemAddr_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        WriteL_i,
    input  logic        WriteR_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] MemData_o,
    output logic        Ready_o,
    output logic        AddrErr_o
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [15:0] ReadCount_o,
    output logic [15:0] WriteCount_o
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic STATE_INIT = 1'b0;
    localparam logic STATE_IDLE = 1'b1;

    logic              state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              ready_q, ready_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              addr_err_q, addr_err_d;

    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        offset;
    logic              out_of_range;
    logic              serving;
    logic              rd_acc;
    logic              wr_acc;
    logic [3:0]        lane_en;

    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_widx;
    logic [31:0]       mem_wdata;

    assign word_idx = MemAddr_i[ADDR_W+1:2];
    assign offset   = MemAddr_i[1:0];

    // With ADDR_W=14 the whole 16-bit address is decoded, so nothing is out of range.
    generate
        if (ADDR_W < 14) begin : g_range_chk
            assign out_of_range = |MemAddr_i[15:ADDR_W+2];
        end else begin : g_no_range_chk
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign serving = (state_q == STATE_IDLE);
    assign rd_acc  = serving & MemRead_i;
    assign wr_acc  = serving & MemWrite_i & ~out_of_range;

    always_comb begin
        lane_en = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            case ({WriteL_i, WriteR_i})
                2'b10:   lane_en[k] = (2'(k) >= offset);
                2'b01:   lane_en[k] = (2'(k) <= offset);
                2'b11:   lane_en[k] = (2'(k) == offset);
                default: lane_en[k] = 1'b1;
            endcase
        end
    end

    // Single write port shared by the zero-fill and core stores.
    always_comb begin
        mem_we    = 4'b0000;
        mem_widx  = word_idx;
        mem_wdata = WriteData_i;
        if (state_q == STATE_INIT) begin
            mem_we    = 4'b1111;
            mem_widx  = init_cnt_q;
            mem_wdata = 32'h0;
        end else if (wr_acc) begin
            mem_we = lane_en;
        end
        if (Reset_i) begin
            mem_we = 4'b0000;
        end
    end

    always_ff @(posedge Clock_i) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) begin
                mem_q[mem_widx][31-8*k -: 8] <= mem_wdata[31-8*k -: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        mem_data_d = mem_data_q;
        addr_err_d = 1'b0;
        case (state_q)
            STATE_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = STATE_IDLE;
                    ready_d = 1'b1;
                end
            end
            STATE_IDLE: begin
                // The array read sees the pre-write word, giving read-first
                // ordering for a same-cycle read and write.
                if (rd_acc) begin
                    mem_data_d = out_of_range ? 32'h0 : mem_q[word_idx];
                end
                // A misaligned offset is only an error for full-word accesses;
                // partial stores use it to select lanes.
                addr_err_d = ((MemRead_i | MemWrite_i) & out_of_range)
                           | ((offset != 2'b00)
                              & (MemRead_i | (MemWrite_i & ~WriteL_i & ~WriteR_i)));
            end
            default: begin
                state_d = STATE_INIT;
            end
        endcase
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q    <= STATE_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            mem_data_q <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            mem_data_q <= mem_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign MemData_o = mem_data_q;
    assign Ready_o   = ready_q;
    assign AddrErr_o = addr_err_q;

`ifdef DATA_MEM_STATS_EN
    logic [15:0] read_cnt_q, read_cnt_d;
    logic [15:0] write_cnt_q, write_cnt_d;

    always_comb begin
        read_cnt_d  = read_cnt_q;
        write_cnt_d = write_cnt_q;
        if (rd_acc && (read_cnt_q != 16'hFFFF)) begin
            read_cnt_d = read_cnt_q + 16'd1;
        end
        if (wr_acc && (write_cnt_q != 16'hFFFF)) begin
            write_cnt_d = write_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            read_cnt_q  <= 16'h0;
            write_cnt_q <= 16'h0;
        end else begin
            read_cnt_q  <= read_cnt_d;
            write_cnt_q <= write_cnt_d;
        end
    end

    assign ReadCount_o  = read_cnt_q;
    assign WriteCount_o = write_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder with ADDR_W=4 (16 words). Inputs are
// driven on the falling edge; outputs are checked on the next falling edge,
// i.e. in the response cycle. Define DATA_MEM_STATS_EN to also exercise the
// read/write counters.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic        MemWrite;
    logic        WriteL;
    logic        WriteR;
    logic [31:0] WriteData;
    logic [31:0] MemData;
    logic        Ready;
    logic        AddrErr;
`ifdef DATA_MEM_STATS_EN
    logic [15:0] ReadCount;
    logic [15:0] WriteCount;
`endif

    int errors = 0;
    int checks = 0;

    data_mem_responder #(.ADDR_W(4)) dut (
        .Clock_i    (Clock),
        .Reset_i    (Reset),
        .MemAddr_i  (MemAddr),
        .MemRead_i  (MemRead),
        .MemWrite_i (MemWrite),
        .WriteL_i   (WriteL),
        .WriteR_i   (WriteR),
        .WriteData_i(WriteData),
        .MemData_o  (MemData),
        .Ready_o    (Ready),
        .AddrErr_o  (AddrErr)
`ifdef DATA_MEM_STATS_EN
        ,
        .ReadCount_o (ReadCount),
        .WriteCount_o(WriteCount)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MemAddr   = 16'h0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        WriteL    = 1'b0;
        WriteR    = 1'b0;
        WriteData = 32'h0;
    endtask

    // Drive one request for one cycle; returns at the falling edge of the
    // response cycle.
    task automatic req(input logic [15:0] a, input logic rd, input logic wr,
                       input logic l, input logic r, input logic [31:0] d);
        MemAddr   = a;
        MemRead   = rd;
        MemWrite  = wr;
        WriteL    = l;
        WriteR    = r;
        WriteData = d;
        @(negedge Clock);
        idle_inputs();
    endtask

    // Release reset at the current falling edge and count cycles until Ready.
    // With junk set, a misaligned read+write is held on the port during init
    // and must be ignored.
    task automatic release_and_wait(input logic junk, input string tag);
        int n;
        n = 0;
        Reset = 1'b0;
        if (junk) begin
            MemAddr   = 16'h0001;
            MemRead   = 1'b1;
            MemWrite  = 1'b1;
            WriteData = 32'hFFFF_FFFF;
        end
        while (Ready !== 1'b1 && n < 64) begin
            check({tag, "_init_addrerr"}, 32'(AddrErr), 32'h0);
            check({tag, "_init_memdata"}, MemData, 32'h0);
            n++;
            @(negedge Clock);
        end
        idle_inputs();
        check({tag, "_init_cycles"}, 32'(n), 32'd16);
        check({tag, "_ready"}, 32'(Ready), 32'h1);
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge Clock);
        check("rst_memdata", MemData, 32'h0);
        check("rst_ready", 32'(Ready), 32'h0);
        check("rst_addrerr", 32'(AddrErr), 32'h0);

        release_and_wait(1'b1, "boot");

        for (int i = 0; i < 16; i++) begin
            req(16'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            check("zero_fill", MemData, 32'h0);
        end

        // Full word write then read
        req(16'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("wr_addrerr", 32'(AddrErr), 32'h0);
        req(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rd_word2", MemData, 32'hDEAD_BEEF);
        @(negedge Clock);
        check("rd_hold", MemData, 32'hDEAD_BEEF);

        // Partial stores into word 4
        req(16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1122_3344);
        req(16'h0011, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00AA_BBCC);
        check("swl_addrerr", 32'(AddrErr), 32'h0);
        req(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("swl_word", MemData, 32'h11AA_BBCC);
        req(16'h0012, 1'b0, 1'b1, 1'b0, 1'b1, 32'hEEFF_9900);
        req(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("swr_word", MemData, 32'hEEFF_99CC);
        req(16'h0013, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0077);
        check("sb_addrerr", 32'(AddrErr), 32'h0);
        req(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("sb_word", MemData, 32'hEEFF_9977);

        // Out-of-range accesses
        req(16'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0055);
        check("oor_wr_addrerr", 32'(AddrErr), 32'h1);
        @(negedge Clock);
        check("oor_wr_pulse_end", 32'(AddrErr), 32'h0);
        req(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("oor_wr_suppressed", MemData, 32'h0);
        req(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_oor_rd", MemData, 32'hDEAD_BEEF);
        req(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("oor_rd_data", MemData, 32'h0);
        check("oor_rd_addrerr", 32'(AddrErr), 32'h1);
        @(negedge Clock);
        check("oor_rd_pulse_end", 32'(AddrErr), 32'h0);

        // Same-cycle read and write: read-first
        req(16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001);
        req(16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0002);
        check("rw_read_first", MemData, 32'h0000_0001);
        req(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rw_new_data", MemData, 32'h0000_0002);

        // Misaligned full-word read and write
        req(16'h000A, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("mis_rd_data", MemData, 32'hDEAD_BEEF);
        check("mis_rd_addrerr", 32'(AddrErr), 32'h1);
        req(16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00AB);
        check("mis_wr_addrerr", 32'(AddrErr), 32'h1);
        req(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("mis_wr_data", MemData, 32'h0000_00AB);
        check("aligned_rd_addrerr", 32'(AddrErr), 32'h0);

        // Reset in the middle of init restarts the full zero-fill
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        repeat (5) @(negedge Clock);
        check("mid_init_ready", 32'(Ready), 32'h0);
        Reset = 1'b1;
        @(negedge Clock);
        release_and_wait(1'b1, "reinit");
        req(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("reinit_zero_w2", MemData, 32'h0);
        req(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("reinit_zero_w4", MemData, 32'h0);

`ifdef DATA_MEM_STATS_EN
        check("stats_rd_after_rst", 32'(ReadCount), 32'd2);
        check("stats_wr_after_rst", 32'(WriteCount), 32'd0);
        req(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        req(16'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
        req(16'h0200, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2);
        check("stats_wr_oor_excl", 32'(WriteCount), 32'd1);
        req(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("stats_rd_oor_incl", 32'(ReadCount), 32'd4);
        Reset = 1'b1;
        @(negedge Clock);
        release_and_wait(1'b0, "stats");
        check("stats_rd_cleared", 32'(ReadCount), 32'd0);
        check("stats_wr_cleared", 32'(WriteCount), 32'd0);
        req(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        req(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        req(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        req(16'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
        req(16'h0300, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3);
        req(16'h000C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2);
        check("stats_rd3", 32'(ReadCount), 32'd3);
        check("stats_wr2", 32'(WriteCount), 32'd2);
        MemAddr = 16'h0000;
        MemRead = 1'b1;
        repeat (70000) @(negedge Clock);
        idle_inputs();
        check("stats_rd_sat", 32'(ReadCount), 32'h0000_FFFF);
        @(negedge Clock);
        check("stats_rd_sat_hold", 32'(ReadCount), 32'h0000_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
